// File: rtl/quad_knob.sv
// rtl/quad_knob.sv - one rotary-encoder channel: sync, debounce, quadrature decode, level register.
// Optional QUAD_KNOB_WRAP_EN: level wraps modulo 2^WIDTH instead of saturating.
module quad_knob #(
  parameter int WIDTH       = 8,
  parameter int DB_LEN      = 8,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  output logic [WIDTH-1:0] value,
  output logic             changed,
  output logic             dir,
  output logic             err
);

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S10 = 2'b10,
    S11 = 2'b11
  } quad_t;

  localparam logic signed [3:0] ACC_MAX = 4'sd4;
  localparam logic signed [3:0] ACC_MIN = -4'sd4;
  localparam logic [WIDTH-1:0]  MAX_VAL = '1;
  localparam logic [WIDTH-1:0]  ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0]  RST_VAL = WIDTH'(RESET_VALUE);

  // Reset asserts asynchronously but is released only on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic [1:0]        a_sync, b_sync;
  logic [DB_LEN-1:0] a_hist, b_hist;
  logic              a_db, b_db;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync <= '0;
      b_sync <= '0;
      a_hist <= '0;
      b_hist <= '0;
      a_db   <= 1'b0;
      b_db   <= 1'b0;
    end else begin
      a_sync <= {a_sync[0], a};
      b_sync <= {b_sync[0], b};
      a_hist <= {a_hist[DB_LEN-2:0], a_sync[1]};
      b_hist <= {b_hist[DB_LEN-2:0], b_sync[1]};
      if (&a_hist)       a_db <= 1'b1;
      else if (~|a_hist) a_db <= 1'b0;
      if (&b_hist)       b_db <= 1'b1;
      else if (~|b_hist) b_db <= 1'b0;
    end
  end

  quad_t                cur, prev;
  logic signed [3:0]    acc, acc_sum, acc_next, step;
  logic                 illegal, commit, up_hit, dn_hit;
  logic [WIDTH-1:0]     value_next;
  logic                 changed_next, dir_next;

  assign cur = quad_t'({a_db, b_db});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev    <= S00;
      acc     <= '0;
      value   <= RST_VAL;
      changed <= 1'b0;
      dir     <= 1'b0;
      err     <= 1'b0;
    end else begin
      prev    <= cur;
      acc     <= commit ? 4'sd0 : acc_next;
      value   <= value_next;
      changed <= changed_next;
      dir     <= dir_next;
      err     <= illegal;
    end
  end

  // Forward order is 00 -> 10 -> 11 -> 01 -> 00.
  always_comb begin
    step    = 4'sd0;
    illegal = ((prev ^ cur) == 2'b11);
    case (prev)
      S00: if (cur == S10) step = 4'sd1; else if (cur == S01) step = -4'sd1;
      S10: if (cur == S11) step = 4'sd1; else if (cur == S00) step = -4'sd1;
      S11: if (cur == S01) step = 4'sd1; else if (cur == S10) step = -4'sd1;
      S01: if (cur == S00) step = 4'sd1; else if (cur == S11) step = -4'sd1;
      default: step = 4'sd0;
    endcase
    acc_sum = acc + step;
    if (acc_sum > ACC_MAX)      acc_next = ACC_MAX;
    else if (acc_sum < ACC_MIN) acc_next = ACC_MIN;
    else                        acc_next = acc_sum;
    commit = (cur == S00) && (prev != S00);
    up_hit = commit && (acc_next == ACC_MAX);
    dn_hit = commit && (acc_next == ACC_MIN);
  end

  always_comb begin
    value_next   = value;
    changed_next = 1'b0;
    dir_next     = dir;
    if (up_hit) begin
      dir_next = 1'b1;
`ifdef QUAD_KNOB_WRAP_EN
      value_next   = value + ONE;
      changed_next = 1'b1;
`else
      if (value != MAX_VAL) begin
        value_next   = value + ONE;
        changed_next = 1'b1;
      end
`endif
    end else if (dn_hit) begin
      dir_next = 1'b0;
`ifdef QUAD_KNOB_WRAP_EN
      value_next   = value - ONE;
      changed_next = 1'b1;
`else
      if (value != '0) begin
        value_next   = value - ONE;
        changed_next = 1'b1;
      end
`endif
    end
  end

endmodule
